// File: rtl/uart_rx_deserializer.sv
// 16x-oversampled UART receiver: recovers LSB-first frames from rx and strobes good bytes to the RX FIFO.
// Optional macro UART_RX_PARITY_EN switches the frame from 8N1 to 8E1 (even parity checked before stop).
`timescale 1ns/1ps

module uart_rx_deserializer #(
  parameter int unsigned CLK_DIV = 326
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       write_flag,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic       rx_meta;
  logic       rxs;
  logic [15:0] div_cnt;
  logic       tick;
  logic [2:0] state;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       brk_hold;
  logic       par_ok;

  // Both stages reset high so a reset never looks like a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tick = (div_cnt == 16'(CLK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 16'd1;
  end

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign par_ok = !par_err;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_out    <= 8'h00;
      write_flag  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      brk_hold    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      // NOTE: the strobes default low here and a later non-blocking assignment in the
      // same block overrides it, which is what makes them exactly one clock wide.
      write_flag  <= 1'b0;
      frame_error <= 1'b0;
      // Any high level on the line ends a break, re-arming frame_error.
      if (rxs) brk_hold <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            os_cnt  <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              if (!rxs) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              shift   <= {rxs, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
                os_cnt <= '0;
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              par_err <= rxs ^ (^shift);
              state   <= STOP;
              os_cnt  <= '0;
              bit_cnt <= '0;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              state   <= IDLE;
              os_cnt  <= '0;
              bit_cnt <= '0;
              busy    <= 1'b0;
              if (rxs && par_ok) begin
                data_out   <= shift;
                write_flag <= 1'b1;
              end else if (rxs || !brk_hold) begin
                frame_error <= 1'b1;
              end
              // A low stop bit may be the start of a break; repeats stay silent until rx rises.
              if (!rxs) brk_hold <= 1'b1;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus random frames against a
// frame-level scoreboard (expected bytes and error count derived from what was put on the line).
`timescale 1ns/1ps

module tb_uart_rx_deserializer;

  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int LAT_TCK = 168;
`else
  localparam int NBITS   = 10;
  localparam int LAT_TCK = 152;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       write_flag;
  logic       frame_error;
  logic       busy;

  uart_rx_deserializer #(.CLK_DIV(CLK_DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .write_flag  (write_flag),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  always @(posedge clock) cyc++;

  // Monitor: everything the DUT emits, sampled on the falling edge.
  logic [7:0]  got_q[$];
  int unsigned wr_cyc_q[$];
  int          err_cnt   = 0;
  int          both_cnt  = 0;
  int          wide_cnt  = 0;
  bit          busy_seen = 1'b0;
  bit          wf_d      = 1'b0;
  bit          fe_d      = 1'b0;

  always @(negedge clock) begin
    if (write_flag) begin
      got_q.push_back(data_out);
      wr_cyc_q.push_back(cyc);
    end
    if (frame_error) err_cnt++;
    if (write_flag && frame_error) both_cnt++;
    if ((write_flag && wf_d) || (frame_error && fe_d)) wide_cnt++;
    if (busy) busy_seen = 1'b1;
    wf_d = write_flag;
    fe_d = frame_error;
  end

  // Reference model: a frame is accepted only if its stop bit is high and its parity holds.
  logic [7:0] exp_q[$];
  int         exp_err  = 0;
  logic [7:0] exp_last = 8'h00;
  int unsigned start_cyc;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_good, input bit par_flip);
    rx = 1'b0;
    start_cyc = cyc;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, BIT);
`endif
    if (stop_good) drive_bit(1'b1, BIT);
    else begin
      drive_bit(1'b0, (BIT * 3) / 4);
      rx = 1'b1;
    end
`ifdef UART_RX_PARITY_EN
    if (stop_good && !par_flip) begin
`else
    if (stop_good) begin
`endif
      exp_q.push_back(d);
      exp_last = d;
    end else begin
      exp_err++;
    end
  endtask

  task automatic score(input string tag);
    check({tag, " write count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, " byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " frame_error count"}, err_cnt, exp_err);
    check({tag, " data_out held"}, 32'(data_out), 32'(exp_last));
    got_q.delete();
    exp_q.delete();
    wr_cyc_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         good;
    bit         pf;
    int unsigned lat;
    int unsigned gap_cyc;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset data_out", 32'(data_out), 32'h00);
    check("reset write_flag", 32'(write_flag), 32'h0);
    check("reset frame_error", 32'(frame_error), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(2 * BIT);

    // Single byte, with latency from the rx fall to the write strobe
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * BIT);
    if (wr_cyc_q.size() > 0) lat = wr_cyc_q[0] - start_cyc;
    else lat = 0;
    check("latency in window", 32'((lat >= 3 + (LAT_TCK - 1) * CLK_DIV) && (lat <= 4 + LAT_TCK * CLK_DIV)), 32'h1);
    check("busy low after byte", 32'(busy), 32'h0);
    score("single");

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2 * BIT);
    if (wr_cyc_q.size() == 2) gap_cyc = wr_cyc_q[1] - wr_cyc_q[0];
    else gap_cyc = 0;
    check("b2b spacing", 32'((gap_cyc >= NBITS * BIT - CLK_DIV) && (gap_cyc <= NBITS * BIT + CLK_DIV)), 32'h1);
    score("b2b");

    // Start-bit glitch shorter than half a bit
    busy_seen = 1'b0;
    drive_bit(1'b0, 16);
    idle(2 * BIT);
    check("glitch busy pulsed", 32'(busy_seen), 32'h1);
    check("glitch busy idle", 32'(busy), 32'h0);
    score("glitch");
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(BIT);
    score("after glitch");

    // Bad stop bit: error pulse, data_out keeps 0x3C
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(2 * BIT);
    score("bad stop");
    send_frame(8'h81, 1'b1, 1'b0);
    idle(BIT);
    score("after bad stop");

    // Reset after the 4th data bit of 0xC3
    d = 8'hC3;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check("midreset data_out", 32'(data_out), 32'h00);
    check("midreset write_flag", 32'(write_flag), 32'h0);
    check("midreset frame_error", 32'(frame_error), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    exp_last = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2 * BIT);
    score("midreset");
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(BIT);
    score("after midreset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(BIT);
    score("parity good");
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * BIT);
    score("parity bad");
`endif

    // Random frames, random gaps, occasional bad stop or parity
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      pf   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pf   = ($urandom_range(0, 5) == 0);
`endif
      send_frame(d, good, pf);
      if (good && !pf) idle($urandom_range(0, BIT));
      else idle(BIT + $urandom_range(0, BIT));
    end
    idle(2 * BIT);
    score("random");

    check("pulse width one clock", wide_cnt, 0);
    check("write_flag/frame_error exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
